// File: rtl/dmem_responder.sv
// dmem_responder
//   Target end of the MEM-stage load/store interface. It accepts one request
//   at a time through a valid/ready handshake and waits WAIT_CYCLES cycles.
//   It then performs a byte, halfword or word access on an internal
//   word-organised RAM and returns a single-cycle response strobe.
//
// Parameters
//   ADDR_WIDTH   word-address bits; the RAM holds 2^ADDR_WIDTH 32-bit words
//   WAIT_CYCLES  wait states between acceptance and the access (0..15)
//
// Ports
//   clk          clock, rising edge
//   reset        synchronous active-high reset
//   req_valid    request present
//   req_ready    responder can accept a request this cycle
//   req_write    1 = store, 0 = load
//   req_addr     byte address
//   req_wdata    store data, taken from the low lanes
//   req_funct3   access width: 000 byte, 001 halfword, 010 word
//   rsp_valid    one-cycle response strobe
//   rsp_rdata    load data shifted right by 8*addr[1:0]; 0 for stores/errors
//   rsp_err      request was illegal and had no effect
//
// Build option
//   DMEM_MISALIGN_CHK_EN  When defined, the responder flags illegal width
//                         codes, misaligned accesses and out-of-range
//                         addresses as errors. When undefined, it forces
//                         such accesses into alignment or wraps them.

module dmem_responder #(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_funct3;
  logic        r_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [0:DEPTH-1];

  logic                  w_is_byte;
  logic                  w_is_half;
  logic [1:0]            w_off;
  logic [3:0]            w_be;
  logic [31:0]           w_wdata_rep;
  logic [ADDR_WIDTH-1:0] w_idx;
  logic [31:0]           w_word;
  logic                  w_illegal;
  logic                  w_access;
  logic [31:0]           w_upper;

  assign w_is_byte = (r_funct3 == 3'b000);
  assign w_is_half = (r_funct3 == 3'b001);
  assign w_idx     = r_addr[ADDR_WIDTH+1:2];
  assign w_word    = r_mem[w_idx];
  assign w_upper   = r_addr >> (ADDR_WIDTH + 2);

  // The effective byte offset forces halfwords and words into alignment.
  // For requests that are legal under the checked build, this leaves
  // the offset unchanged. Any code that is neither byte nor halfword is
  // treated as a word access.
  always_comb begin
    w_off = 2'b00;
    w_be  = 4'b1111;
    if (w_is_byte) begin
      w_off = r_addr[1:0];
      w_be  = 4'b0001 << r_addr[1:0];
    end else if (w_is_half) begin
      w_off = {r_addr[1], 1'b0};
      w_be  = r_addr[1] ? 4'b1100 : 4'b0011;
    end
  end

  // Replicate the store data so that whichever lane is enabled
  // sees the right byte.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata_rep[8*gi +: 8] = w_is_byte ? r_wdata[7:0] :
                                      w_is_half ? r_wdata[8*(gi%2) +: 8] :
                                                  r_wdata[8*gi +: 8];
    end
  endgenerate

`ifdef DMEM_MISALIGN_CHK_EN
  assign w_illegal = (r_funct3 > 3'b010)
                   | (w_is_half && r_addr[0])
                   | ((r_funct3 == 3'b010) && (r_addr[1:0] != 2'b00))
                   | (w_upper != 32'd0);
`else
  // Upper address bits are ignored, so accesses wrap modulo the RAM size.
  logic w_unused_upper;
  assign w_unused_upper = |w_upper;
  assign w_illegal      = 1'b0;
`endif

  // The access edge is the last BUSY cycle. Gating it with reset
  // keeps a reset on that edge from committing the store.
  assign w_access = (r_state == BUSY) && (r_cnt == 4'd0) && !reset;

  // RAM contents are never reset.
  always_ff @(posedge clk) begin
    if (w_access && r_write && !w_illegal) begin
      for (int i = 0; i < 4; i++) begin
        if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata_rep[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_ready     <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rdata     <= 32'd0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_write  <= req_write;
            r_addr   <= req_addr;
            r_wdata  <= req_wdata;
            r_funct3 <= req_funct3;
            r_cnt    <= 4'(WAIT_CYCLES);
            r_ready  <= 1'b0;
            r_state  <= BUSY;
          end
        end
        BUSY: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_rsp_valid <= 1'b1;
            r_err       <= w_illegal;
            r_rdata     <= (r_write || w_illegal) ? 32'd0 : (w_word >> {w_off, 3'b000});
            r_state     <= RESP;
          end
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_ready     <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = r_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

endmodule
